// File: rtl/mem_pkg.sv
// Shared definitions for the byte-addressable data memory: access-size codes,
// access FSM encoding and the alignment rule.
package mem_pkg;

  localparam logic [1:0] MOD_WORD = 2'b00;
  localparam logic [1:0] MOD_HALF = 2'b01;
  localparam logic [1:0] MOD_BYTE = 2'b1?;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  // Bytes never fault; halves need an even address; words need addr[1:0]==0.
  function automatic logic misaligned(input logic [1:0] mod, input logic [1:0] addr_lo);
    logic mis;
    if (mod[1]) begin
      mis = 1'b0;
    end else if (mod[0]) begin
      mis = addr_lo[0];
    end else begin
      mis = (addr_lo != 2'b00);
    end
    return mis;
  endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// Request/response bus of the data memory LSU; the memory is the slave side.
interface data_mem_lsu_if #(
  parameter int ADDR_W = 8
);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_mod;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  modport master (
    output req_valid, req_we, req_mod, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_mod, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_lane_align.sv
// Little-endian lane steering: byte enables and write-data replication for
// stores, lane extraction and sign/zero extension for loads.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  mod,
  input  logic [1:0]  addr_lo,
  input  logic        is_unsigned,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wdata_rep,
  output logic [31:0] rdata
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rword[{addr_lo, 3'b000} +: 8];
  assign lane_h = addr_lo[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    be        = 4'b0000;
    wdata_rep = wdata;
    rdata     = rword;
    unique casez (mod)
      MOD_WORD: begin
        be = 4'b1111;
      end
      MOD_HALF: begin
        be        = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{wdata[15:0]}};
        rdata     = is_unsigned ? {16'h0000, lane_h} : {{16{lane_h[15]}}, lane_h};
      end
      MOD_BYTE: begin
        be        = 4'b0001 << addr_lo;
        wdata_rep = {4{wdata[7:0]}};
        rdata     = is_unsigned ? {24'h000000, lane_b} : {{24{lane_b[7]}}, lane_b};
      end
      default: begin
        be = 4'b0000;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_lsu.sv
// Byte-addressable data memory with sized loads/stores behind a valid-ready
// request/response bus; one access in flight, IDLE -> ACCESS -> RESP.
module data_mem_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 32,
  parameter     INIT_FILE = ""
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_lsu_if.slave  bus
);

  localparam int DEPTH = 2 ** (ADDR_W - 2);

  logic [DATA_W-1:0] mem [DEPTH];

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        mod_q, mod_d;
  logic              we_q, we_d;
  logic              uns_q, uns_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;

  logic [3:0]        be;
  logic [31:0]       wdata_rep;
  logic [31:0]       rword;
  logic [31:0]       load_data;
  logic              store_en;

  assign rword    = mem[addr_q[ADDR_W-1:2]];
  assign store_en = (state_q == ST_ACCESS) && we_q;

  mem_lane_align u_lane (
    .mod         (mod_q),
    .addr_lo     (addr_q[1:0]),
    .is_unsigned (uns_q),
    .wdata       (wdata_q),
    .rword       (rword),
    .be          (be),
    .wdata_rep   (wdata_rep),
    .rdata       (load_data)
  );

  // Async reset forces state_q to IDLE, so a store is dropped if reset is
  // still low at the ACCESS edge.
  always_ff @(posedge clk) begin
    if (store_en) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) begin
          mem[addr_q[ADDR_W-1:2]][8*b +: 8] <= wdata_rep[8*b +: 8];
        end
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    mod_d       = mod_q;
    we_d        = we_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid) begin
          addr_d      = bus.req_addr;
          mod_d       = bus.req_mod;
          we_d        = bus.req_we;
          uns_d       = bus.req_unsigned;
          wdata_d     = bus.req_wdata;
          rsp_rdata_d = 32'h0;
          if (misaligned(bus.req_mod, bus.req_addr[1:0])) begin
            state_d   = ST_RESP;
            rsp_err_d = 1'b1;
          end else begin
            state_d   = ST_ACCESS;
            rsp_err_d = 1'b0;
          end
        end
      end
      ST_ACCESS: begin
        state_d     = ST_RESP;
        rsp_rdata_d = we_q ? 32'h0 : load_data;
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      addr_q      <= '0;
      mod_q       <= MOD_WORD;
      we_q        <= 1'b0;
      uns_q       <= 1'b0;
      wdata_q     <= '0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      mod_q       <= mod_d;
      we_q        <= we_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready = rst_n && (state_q == ST_IDLE);
  assign bus.rsp_valid = (state_q == ST_RESP);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule
